// File: rtl/tree_reduction_sequencer_if.sv
// Chunk-in / scalar-out bundle for tree_reduction_sequencer.
//
// Handshake rules, identical on both channels:
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. The source holds its payload stable while valid is high and ready
//   is low. Ready does not depend combinationally on valid.
//
// Signals
//   cfg_chunks : chunk count for the next reduction (read on its first chunk)
//   in_valid   : chunk lanes on in_data are valid
//   in_ready   : sequencer can take a chunk
//   in_data    : INPUTS_AMOUNT lanes of P bits, lane i at in_data[i]
//   out_valid  : out_sum / out_ovf hold a finished result
//   out_ready  : consumer takes the result
//   out_sum    : signed reduction result (wraps modulo 2^P)
//   out_ovf    : sticky signed overflow of the accumulator adds
//   busy       : a reduction is in progress or its result is pending
//   dbg_state  : raw FSM state, for observation only
interface tree_reduction_sequencer_if #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 16,
  parameter int CW            = 5
);
  logic [CW-1:0]                  cfg_chunks;
  logic                           in_valid;
  logic                           in_ready;
  logic [INPUTS_AMOUNT-1:0][P-1:0] in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [P-1:0]            out_sum;
  logic                           out_ovf;
  logic                           busy;
  logic [1:0]                     dbg_state;

  // Producer/consumer side.
  modport master (
    output cfg_chunks, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  cfg_chunks, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy, dbg_state
  );
endinterface

// File: rtl/tree_reduction_sequencer.sv
// Reduces a vector delivered as a stream of INPUTS_AMOUNT-lane chunks to one
// signed P-bit scalar. Each chunk goes through a combinational binary tree
// adder; chunk sums are accumulated in a register with a sticky signed
// overflow flag. The scalar is offered on a valid/ready output.
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset, wins over any handshake
//   bus : tree_reduction_sequencer_if.slave (chunk input, result output)

// Combinational wrap-around sum of N lanes, paired level by level.
module binary_tree_adder #(
  parameter int N = 8,
  parameter int P = 16
) (
  input  logic [N-1:0][P-1:0] lanes_i,
  output logic [P-1:0]        sum_o
);
  logic [P-1:0] node [N];

  // In-place pairing: at width w, node[i] <= node[2i] + node[2i+1]. Every
  // write index i is at or below the indices already read in that level.
  always_comb begin
    for (int i = 0; i < N; i++) node[i] = lanes_i[i];
    for (int w = N / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) node[i] = node[2*i] + node[2*i+1];
    end
    sum_o = node[0];
  end
endmodule

module tree_reduction_sequencer #(
  parameter  int INPUTS_AMOUNT = 8,
  parameter  int P             = 16,
  parameter  int MAX_CHUNKS    = 16,
  localparam int CW            = $clog2(MAX_CHUNKS + 1)
) (
  input logic                      clk,
  input logic                      rst,
  tree_reduction_sequencer_if.slave bus
);
  if ((INPUTS_AMOUNT < 1) || ((INPUTS_AMOUNT & (INPUTS_AMOUNT - 1)) != 0)) begin : g_bad_lanes
    $fatal(1, "INPUTS_AMOUNT must be a power of 2");
  end
  if (MAX_CHUNKS < 1) begin : g_bad_max
    $fatal(1, "MAX_CHUNKS must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       tgt_q;
  logic signed [P-1:0] acc_q;
  logic                ovf_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [P-1:0]        tsum;
  logic signed [P-1:0] sum_d;
  logic                add_ovf_d;
  logic [CW-1:0]       tgt_d;
  logic [CW-1:0]       cnt_d;

  binary_tree_adder #(.N(INPUTS_AMOUNT), .P(P)) u_tree (
    .lanes_i (bus.in_data),
    .sum_o   (tsum)
  );

  always_comb begin
    sum_d = acc_q + $signed(tsum);
    // Signed overflow: operands agree in sign, result does not.
    add_ovf_d = (acc_q[P-1] == tsum[P-1]) && (sum_d[P-1] != acc_q[P-1]);
    cnt_d = cnt_q + CW'(1);
    // Zero chunks means one; anything beyond capacity is clamped.
    if (bus.cfg_chunks == '0)                    tgt_d = CW'(1);
    else if (bus.cfg_chunks > CW'(MAX_CHUNKS))   tgt_d = CW'(MAX_CHUNKS);
    else                                         tgt_d = bus.cfg_chunks;
  end

  // Control outputs are registered alongside the state so no input reaches
  // an output port combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            tgt_q  <= tgt_d;
            acc_q  <= $signed(tsum);
            cnt_q  <= CW'(1);
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (tgt_d == CW'(1)) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            acc_q <= sum_d;
            ovf_q <= ovf_q | add_ovf_d;
            cnt_q <= cnt_d;
            if (cnt_d == tgt_q) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;
endmodule
